exc_ctrl: RTL and testbench
===========================

Name: exc_ctrl

Overview:
Exception control unit for the CP0 block. It generalises one-hot exception decoding to NSTAGE pipeline stages plus masked interrupts. Each cycle it selects the oldest pending exception and latches Cause.ExcCode, EPC, BD and BadVAddr. It then issues a one-cycle pipeline flush and redirect, tracks EXL, and returns from the handler on ERET.

Parameters:
NSTAGE, 4, number of reporting pipeline stages; index 0 = youngest (fetch), NSTAGE-1 = oldest.
AW, 32, PC and address width.
EXC_W, 5, exception code width (Cause.ExcCode).
INT_W, 6, number of interrupt request lines.
VEC_ADDR, 32'h8000_0180, general exception vector.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-high.
exc_valid  in  NSTAGE  per-stage exception pending.
exc_code  in  NSTAGE*EXC_W  per-stage code; stage i occupies bits [i*EXC_W +: EXC_W].
exc_pc  in  NSTAGE*AW  per-stage faulting instruction PC.
exc_bd  in  NSTAGE  per-stage instruction is in a branch delay slot.
exc_badva  in  NSTAGE*AW  per-stage faulting address; meaningful only for AdEL/AdES.
int_req  in  INT_W  interrupt request lines (already synchronised).
int_mask  in  INT_W  Status.IM.
ie  in  1  Status.IE.
int_pc  in  AW  PC of the oldest in-flight instruction; this is the interrupt EPC.
int_bd  in  1  BD flag for int_pc.
eret  in  1  ERET retiring in the oldest stage.
flush  out  1  one-cycle pipeline flush/redirect pulse.
flush_mask  out  NSTAGE  stages to kill during the flush cycle.
redirect_pc  out  AW  target PC; valid while flush=1.
exl  out  1  Status.EXL.
epc  out  AW  EPC register.
cause_code  out  EXC_W  Cause.ExcCode.
cause_bd  out  1  Cause.BD.
cause_ip  out  INT_W  Cause.IP; live copy of int_req.
badvaddr  out  AW  BadVAddr register.

Behaviour:
- Reset values: flush=0, flush_mask=0, redirect_pc=0, exl=0, epc=0, cause_code=0, cause_bd=0, badvaddr=0; state=IDLE.
- State machine has two states: IDLE and FLUSH.
- Selection in IDLE, combinational: take the highest index i with exc_valid[i]=1.
  - If no stage is valid, an interrupt is taken when ie=1, exl=0 and (int_req & int_mask) != 0. Its code is INT, EPC source is int_pc and BD source is int_bd.
  - Synchronous exceptions always beat interrupts.
- Event taken, IDLE -> FLUSH; all updates land on the next edge (1-cycle latency):
  - cause_code <= selected code.
  - cause_bd and epc update only when exl=0:
    - epc <= bd ? pc-4 (mod 2^AW) : pc.
    - cause_bd <= bd.
    - When exl=1, epc and cause_bd hold their values.
  - badvaddr <= exc_badva[i] only when the code is ADEL or ADES; otherwise it holds.
  - exl <= 1, flush <= 1, redirect_pc <= VEC_ADDR.
  - flush_mask <= bits 0..i set. For an interrupt, flush_mask = all ones.
- ERET in IDLE with exl=1 and no exception selected:
  - Next edge: exl <= 0, flush <= 1, redirect_pc <= epc, flush_mask <= all ones; go to FLUSH.
  - ERET with exl=0 is ignored.
- Exception and ERET in the same cycle: the exception wins and ERET is dropped.
- FLUSH state lasts exactly one cycle:
  - All inputs are ignored.
  - flush, flush_mask and redirect_pc clear on the next edge; state returns to IDLE.
  - Back-to-back events are therefore separated by at least one flush cycle.
- cause_ip <= int_req every cycle, in every state.
- Reset asserted mid-FLUSH: all outputs go to their reset values immediately (asynchronous).
- Unknown codes are latched verbatim; no code gets special handling except ADEL/ADES (badvaddr) and INT.

Decomposition:
- Package exc_pkg holds:
  - ExcCode constants: INT=0, ADEL=4, ADES=5, IBE=6, DBE=7, SYS=8, BP=9, RI=10, CPU=11, OV=12, TR=13.
  - State encoding for IDLE and FLUSH.
- Sub-module exc_prio_sel: combinational oldest-first selector. Outputs hit, index, code, pc, bd, badva, parametrised by NSTAGE/AW/EXC_W.
- The top level holds the FSM and the CP0 registers.

Test Plan:
1. exc_valid=4'b0010, stage-1 code=SYS, pc=0x400010, bd=0 -> next cycle:
   - flush=1 for exactly 1 cycle, flush_mask=0011, redirect_pc=0x80000180.
   - cause_code=8, epc=0x400010, exl=1; badvaddr unchanged.
2. Simultaneous stage-0 code=ADEL and stage-3 code=OV, stage-3 pc=0x400100, bd=1 -> cause_code=12, epc=0x4000FC, cause_bd=1, flush_mask=1111, badvaddr unchanged.
3. Stage-2 code=ADES, badva=0x00000003 -> badvaddr=0x00000003, cause_code=5.
   Then ERET with exl=1 -> flush=1, redirect_pc=epc, exl=0.
4. While exl=1, stage-1 code=RI, pc=0x500 -> cause_code=10, epc and cause_bd unchanged, flush=1.
   Same cycle with ERET=1 -> exl stays 1, no return redirect.
5. Interrupt gating, int_req=6'b000100, int_mask=6'b000100:
   - With ie=0 -> no flush.
   - With ie=1, exl=0, int_pc=0x600 -> cause_code=0, epc=0x600, flush_mask=1111, cause_ip=000100.
6. Event cycle 0 with new exc_valid held during the FLUSH cycle -> the second event is taken in cycle 2.
   rst pulsed mid-FLUSH -> flush=0, exl=0 immediately.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared definitions for the CP0 exception controller: Cause.ExcCode values and FSM encoding.
package exc_pkg;

  localparam int INT  = 0;
  localparam int ADEL = 4;
  localparam int ADES = 5;
  localparam int IBE  = 6;
  localparam int DBE  = 7;
  localparam int SYS  = 8;
  localparam int BP   = 9;
  localparam int RI   = 10;
  localparam int CPU  = 11;
  localparam int OV   = 12;
  localparam int TR   = 13;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/exc_prio_sel.sv
// Oldest-first exception selector: the highest-indexed valid stage wins.
module exc_prio_sel #(
  parameter int NSTAGE = 4,
  parameter int AW     = 32,
  parameter int EXC_W  = 5,
  localparam int IW    = (NSTAGE > 1) ? $clog2(NSTAGE) : 1
) (
  input  logic [NSTAGE-1:0]       exc_valid,
  input  logic [NSTAGE*EXC_W-1:0] exc_code,
  input  logic [NSTAGE*AW-1:0]    exc_pc,
  input  logic [NSTAGE-1:0]       exc_bd,
  input  logic [NSTAGE*AW-1:0]    exc_badva,
  output logic                    hit,
  output logic [IW-1:0]           index,
  output logic [EXC_W-1:0]        code,
  output logic [AW-1:0]           pc,
  output logic                    bd,
  output logic [AW-1:0]           badva
);

  // Ascending scan, so a later (older) valid stage overrides a younger one.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    code  = '0;
    pc    = '0;
    bd    = 1'b0;
    badva = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (exc_valid[i]) begin
        hit   = 1'b1;
        index = IW'(i);
        code  = exc_code[i*EXC_W +: EXC_W];
        pc    = exc_pc[i*AW +: AW];
        bd    = exc_bd[i];
        badva = exc_badva[i*AW +: AW];
      end
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// CP0 exception control: picks the oldest exception or a masked interrupt, latches
// Cause/EPC/BadVAddr, pulses a one-cycle flush/redirect and handles ERET.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int             NSTAGE   = 4,
  parameter int             AW       = 32,
  parameter int             EXC_W    = 5,
  parameter int             INT_W    = 6,
  parameter logic [AW-1:0]  VEC_ADDR = 32'h8000_0180
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NSTAGE-1:0]       exc_valid,
  input  logic [NSTAGE*EXC_W-1:0] exc_code,
  input  logic [NSTAGE*AW-1:0]    exc_pc,
  input  logic [NSTAGE-1:0]       exc_bd,
  input  logic [NSTAGE*AW-1:0]    exc_badva,
  input  logic [INT_W-1:0]        int_req,
  input  logic [INT_W-1:0]        int_mask,
  input  logic                    ie,
  input  logic [AW-1:0]           int_pc,
  input  logic                    int_bd,
  input  logic                    eret,
  output logic                    flush,
  output logic [NSTAGE-1:0]       flush_mask,
  output logic [AW-1:0]           redirect_pc,
  output logic                    exl,
  output logic [AW-1:0]           epc,
  output logic [EXC_W-1:0]        cause_code,
  output logic                    cause_bd,
  output logic [INT_W-1:0]        cause_ip,
  output logic [AW-1:0]           badvaddr
);

  localparam int IW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

  state_t state, state_next;

  logic              sel_hit;
  logic [IW-1:0]     sel_idx;
  logic [EXC_W-1:0]  sel_code;
  logic [AW-1:0]     sel_pc;
  logic              sel_bd;
  logic [AW-1:0]     sel_badva;

  logic              int_take;
  logic              ev_take;
  logic              eret_take;
  logic [EXC_W-1:0]  ev_code;
  logic [AW-1:0]     ev_pc;
  logic              ev_bd;
  logic [NSTAGE-1:0] ev_mask;
  logic              ev_addr_err;

  exc_prio_sel #(
    .NSTAGE (NSTAGE),
    .AW     (AW),
    .EXC_W  (EXC_W)
  ) u_sel (
    .exc_valid (exc_valid),
    .exc_code  (exc_code),
    .exc_pc    (exc_pc),
    .exc_bd    (exc_bd),
    .exc_badva (exc_badva),
    .hit       (sel_hit),
    .index     (sel_idx),
    .code      (sel_code),
    .pc        (sel_pc),
    .bd        (sel_bd),
    .badva     (sel_badva)
  );

  // Interrupts only when no synchronous exception is pending and not already in a handler.
  assign int_take    = !sel_hit && ie && !exl && (|(int_req & int_mask));
  assign ev_take     = sel_hit || int_take;
  assign eret_take   = eret && exl && !ev_take;
  assign ev_code     = sel_hit ? sel_code : EXC_W'(INT);
  assign ev_pc       = sel_hit ? sel_pc : int_pc;
  assign ev_bd       = sel_hit ? sel_bd : int_bd;
  assign ev_addr_err = sel_hit && (sel_code == EXC_W'(ADEL) || sel_code == EXC_W'(ADES));

  // Kill the faulting stage and everything younger; interrupts kill the whole pipe.
  for (genvar gi = 0; gi < NSTAGE; gi++) begin : g_mask
    assign ev_mask[gi] = !sel_hit || (int'(sel_idx) >= gi);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ev_take || eret_take) state_next = FLUSH;
      FLUSH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush       <= 1'b0;
      flush_mask  <= '0;
      redirect_pc <= '0;
      exl         <= 1'b0;
      epc         <= '0;
      cause_code  <= '0;
      cause_bd    <= 1'b0;
      cause_ip    <= '0;
      badvaddr    <= '0;
    end else begin
      cause_ip    <= int_req;
      flush       <= 1'b0;
      flush_mask  <= '0;
      redirect_pc <= '0;
      if (state == IDLE) begin
        if (ev_take) begin
          cause_code  <= ev_code;
          // Nested exceptions keep the original return point.
          if (!exl) begin
            epc      <= ev_bd ? ev_pc - AW'(4) : ev_pc;
            cause_bd <= ev_bd;
          end
          if (ev_addr_err) badvaddr <= sel_badva;
          exl         <= 1'b1;
          flush       <= 1'b1;
          flush_mask  <= ev_mask;
          redirect_pc <= VEC_ADDR;
        end else if (eret_take) begin
          exl         <= 1'b0;
          flush       <= 1'b1;
          flush_mask  <= '1;
          redirect_pc <= epc;
        end
      end
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: a behavioural model predicts each cycle's registers.
module tb_exc_ctrl;

  localparam int NS = 4;
  localparam logic [31:0] VEC = 32'h8000_0180;

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] exc_valid;
  logic [NS*5-1:0]  exc_code;
  logic [NS*32-1:0] exc_pc;
  logic [NS-1:0] exc_bd;
  logic [NS*32-1:0] exc_badva;
  logic [5:0]    int_req, int_mask;
  logic          ie;
  logic [31:0]   int_pc;
  logic          int_bd;
  logic          eret;
  logic          flush;
  logic [NS-1:0] flush_mask;
  logic [31:0]   redirect_pc, epc, badvaddr;
  logic          exl, cause_bd;
  logic [4:0]    cause_code;
  logic [5:0]    cause_ip;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_bd(exc_bd), .exc_badva(exc_badva), .int_req(int_req), .int_mask(int_mask),
    .ie(ie), .int_pc(int_pc), .int_bd(int_bd), .eret(eret), .flush(flush),
    .flush_mask(flush_mask), .redirect_pc(redirect_pc), .exl(exl), .epc(epc),
    .cause_code(cause_code), .cause_bd(cause_bd), .cause_ip(cause_ip), .badvaddr(badvaddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic [3:0]  mask;
    logic [31:0] redir;
    logic        exl;
    logic [31:0] epc;
    logic [4:0]  code;
    logic        bd;
    logic [5:0]  ip;
    logic [31:0] badva;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  logic m_in_flush;
  int   n_cmp = 0;
  int   n_err = 0;
  int   txn = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m = '{flush: 1'b0, mask: 4'h0, redir: 32'h0, exl: 1'b0, epc: 32'h0,
          code: 5'h0, bd: 1'b0, ip: 6'h0, badva: 32'h0};
    m_in_flush = 1'b0;
  endtask

  task automatic clear_inputs();
    exc_valid = '0; exc_code = '0; exc_pc = '0; exc_bd = '0; exc_badva = '0;
    int_req = '0; int_mask = '0; ie = 1'b0; int_pc = '0; int_bd = 1'b0; eret = 1'b0;
  endtask

  task automatic set_stage(input int i, input logic [4:0] code, input logic [31:0] pc,
                           input logic bd, input logic [31:0] badva);
    exc_valid[i]       = 1'b1;
    exc_code[i*5 +: 5] = code;
    exc_pc[i*32 +: 32] = pc;
    exc_bd[i]          = bd;
    exc_badva[i*32 +: 32] = badva;
  endtask

  // Behavioural prediction of the registers after the coming edge.
  task automatic model_step();
    int found;
    logic take_int;
    logic [4:0] c;
    logic [31:0] p;
    logic b;
    found = -1;
    for (int i = NS - 1; i >= 0; i--)
      if (found < 0 && exc_valid[i]) found = i;
    take_int = (found < 0) && ie && !m.exl && ((int_req & int_mask) != 6'h0);
    m.ip = int_req;
    if (m_in_flush) begin
      m.flush = 1'b0; m.mask = 4'h0; m.redir = 32'h0; m_in_flush = 1'b0;
    end else if (found >= 0 || take_int) begin
      c = (found >= 0) ? exc_code[found*5 +: 5] : 5'd0;
      p = (found >= 0) ? exc_pc[found*32 +: 32] : int_pc;
      b = (found >= 0) ? exc_bd[found] : int_bd;
      m.code = c;
      if (!m.exl) begin
        m.epc = b ? p - 32'd4 : p;
        m.bd  = b;
      end
      if (found >= 0 && (c == 5'd4 || c == 5'd5)) m.badva = exc_badva[found*32 +: 32];
      m.mask = 4'h0;
      for (int j = 0; j < NS; j++) if (found < 0 || j <= found) m.mask[j] = 1'b1;
      m.exl = 1'b1; m.flush = 1'b1; m.redir = VEC; m_in_flush = 1'b1;
    end else if (eret && m.exl) begin
      m.exl = 1'b0; m.flush = 1'b1; m.redir = m.epc; m.mask = 4'hF; m_in_flush = 1'b1;
    end else begin
      m.flush = 1'b0; m.mask = 4'h0; m.redir = 32'h0;
    end
  endtask

  // One clock: predict, push, advance, pop and compare.
  task automatic step();
    exp_t e;
    model_step();
    sb.push_back(m);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    txn++;
    $display("txn %0d flush=%0b mask=%b redir=%h exl=%0b epc=%h code=%0d bd=%0b bva=%h",
             txn, flush, flush_mask, redirect_pc, exl, epc, cause_code, cause_bd, badvaddr);
    chk($sformatf("t%0d.flush", txn), 64'(flush), 64'(e.flush));
    chk($sformatf("t%0d.mask", txn), 64'(flush_mask), 64'(e.mask));
    chk($sformatf("t%0d.redir", txn), 64'(redirect_pc), 64'(e.redir));
    chk($sformatf("t%0d.exl", txn), 64'(exl), 64'(e.exl));
    chk($sformatf("t%0d.epc", txn), 64'(epc), 64'(e.epc));
    chk($sformatf("t%0d.code", txn), 64'(cause_code), 64'(e.code));
    chk($sformatf("t%0d.bd", txn), 64'(cause_bd), 64'(e.bd));
    chk($sformatf("t%0d.ip", txn), 64'(cause_ip), 64'(e.ip));
    chk($sformatf("t%0d.badva", txn), 64'(badvaddr), 64'(e.badva));
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.flush", 64'(flush), 64'(0));
    chk("rst.mask", 64'(flush_mask), 64'(0));
    chk("rst.redir", 64'(redirect_pc), 64'(0));
    chk("rst.exl", 64'(exl), 64'(0));
    chk("rst.epc", 64'(epc), 64'(0));
    chk("rst.code", 64'(cause_code), 64'(0));
    chk("rst.badva", 64'(badvaddr), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // 1: single SYS in stage 1
    set_stage(1, 5'd8, 32'h0040_0010, 1'b0, 32'hDEAD_BEEF);
    step();
    chk("tp1.flush", 64'(flush), 64'(1));
    chk("tp1.mask", 64'(flush_mask), 64'(4'b0011));
    chk("tp1.redir", 64'(redirect_pc), 64'(VEC));
    chk("tp1.code", 64'(cause_code), 64'(8));
    chk("tp1.epc", 64'(epc), 64'(32'h0040_0010));
    clear_inputs();
    step();
    chk("tp1.oneshot", 64'(flush), 64'(0));
    eret = 1'b1;
    step();
    chk("eret1.redir", 64'(redirect_pc), 64'(32'h0040_0010));
    eret = 1'b0;
    step();

    // 2: stage 0 ADEL and stage 3 OV in delay slot
    set_stage(0, 5'd4, 32'h0040_0200, 1'b0, 32'h0000_0001);
    set_stage(3, 5'd12, 32'h0040_0100, 1'b1, 32'h0000_0002);
    step();
    chk("tp2.code", 64'(cause_code), 64'(12));
    chk("tp2.epc", 64'(epc), 64'(32'h0040_00FC));
    chk("tp2.bd", 64'(cause_bd), 64'(1));
    chk("tp2.badva", 64'(badvaddr), 64'(0));
    clear_inputs();
    step();
    eret = 1'b1;
    step();
    eret = 1'b0;
    step();

    // 3: ADES latches BadVAddr; 4: nested RI with simultaneous ERET
    set_stage(2, 5'd5, 32'h0040_0300, 1'b0, 32'h0000_0003);
    step();
    chk("tp3.badva", 64'(badvaddr), 64'(32'h3));
    chk("tp3.code", 64'(cause_code), 64'(5));
    clear_inputs();
    step();
    set_stage(1, 5'd10, 32'h0000_0500, 1'b1, 32'h0);
    eret = 1'b1;
    step();
    chk("tp4.code", 64'(cause_code), 64'(10));
    chk("tp4.epc", 64'(epc), 64'(32'h0040_0300));
    chk("tp4.exl", 64'(exl), 64'(1));
    chk("tp4.redir", 64'(redirect_pc), 64'(VEC));
    clear_inputs();
    step();
    eret = 1'b1;
    step();
    chk("tp3.eret", 64'(redirect_pc), 64'(32'h0040_0300));
    chk("tp3.exl", 64'(exl), 64'(0));
    eret = 1'b0;
    step();

    // 5: interrupt gating
    int_req = 6'b000100; int_mask = 6'b000100; int_pc = 32'h600; ie = 1'b0;
    step();
    chk("tp5.gated", 64'(flush), 64'(0));
    ie = 1'b1;
    step();
    chk("tp5.code", 64'(cause_code), 64'(0));
    chk("tp5.epc", 64'(epc), 64'(32'h600));
    chk("tp5.mask", 64'(flush_mask), 64'(4'hF));
    chk("tp5.ip", 64'(cause_ip), 64'(6'b000100));
    clear_inputs();
    step();
    eret = 1'b1;
    step();
    eret = 1'b0;
    step();

    // 6: held exception is re-taken after the flush cycle, then reset mid-FLUSH
    set_stage(0, 5'd13, 32'h0000_0700, 1'b0, 32'h0);
    step();
    step();
    chk("tp6.gap", 64'(flush), 64'(0));
    step();
    chk("tp6.retake", 64'(flush), 64'(1));
    rst = 1'b1;
    #1;
    chk("tp6.rst_flush", 64'(flush), 64'(0));
    chk("tp6.rst_exl", 64'(exl), 64'(0));
    chk("tp6.rst_epc", 64'(epc), 64'(0));
    model_reset();
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;

    // Random traffic against the model
    for (int k = 0; k < 60; k++) begin
      clear_inputs();
      for (int s = 0; s < NS; s++)
        if ($urandom_range(0, 5) == 0)
          set_stage(s, 5'($urandom_range(0, 31)), $urandom & 32'hFFFF_FFFC,
                    1'($urandom_range(0, 1)), $urandom);
      int_req  = 6'($urandom);
      int_mask = 6'($urandom);
      ie       = 1'($urandom_range(0, 1));
      int_pc   = $urandom & 32'hFFFF_FFFC;
      int_bd   = 1'($urandom_range(0, 1));
      eret     = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
